// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the horizontal counter and the sync generator.
// Horizontal values are in clock ticks (2 per pixel); vertical values are in lines.
package vga_timing_pkg;

  localparam int H_W = 11;
  localparam int V_W = 10;

  typedef logic [H_W-1:0] hpos_t;
  typedef logic [V_W-1:0] vline_t;

  localparam hpos_t H_TOTAL      = 11'd1600;
  localparam hpos_t H_VISIBLE    = 11'd1280;
  localparam hpos_t H_SYNC_START = 11'd1312;
  localparam hpos_t H_SYNC_END   = 11'd1503;

  localparam vline_t V_TOTAL      = 10'd525;
  localparam vline_t V_VISIBLE    = 10'd480;
  localparam vline_t V_SYNC_START = 10'd490;
  localparam vline_t V_SYNC_END   = 10'd491;

  // Asserted level of hsync/vsync; 0 gives active-low sync pulses.
  localparam logic SYNC_POL = 1'b0;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Bundle between the horizontal counter side (master) and the sync generator (slave).
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  hpos_t  cntHorizontal;
  logic   vflag;
  vline_t cntVertical;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic [9:0] pixel_x;
  vline_t pixel_y;
  logic   frame_start;

  modport master (
    output cntHorizontal, vflag,
    input  cntVertical, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
  );

  modport slave (
    input  cntHorizontal, vflag,
    output cntVertical, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
  );

endinterface

// File: rtl/vga_sync_gen_contadorvertical.sv
// Mod-V_TOTAL line counter advanced by the end-of-line pulse; also exposes its
// next value so the decoder can see the new line in the same cycle as tick 0.
module contadorvertical
  import vga_timing_pkg::*;
#(
  parameter vline_t V_TOTAL = vga_timing_pkg::V_TOTAL
) (
  input  logic   Clk,
  input  logic   Reset_n,
  input  logic   en,
  output vline_t count,
  output vline_t count_next,
  output logic   wrap
);

  localparam vline_t V_LAST = V_TOTAL - 10'd1;

  logic at_last;

  assign at_last    = (count == V_LAST);
  assign count_next = at_last ? '0 : count + 10'd1;
  assign wrap       = en & at_last;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (en) begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Vertical line tracking plus registered sync, blanking and pixel-coordinate decode
// for the 640x480@60 path, fed by the horizontal tick counter.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter hpos_t  H_VISIBLE    = vga_timing_pkg::H_VISIBLE,
  parameter hpos_t  H_SYNC_START = vga_timing_pkg::H_SYNC_START,
  parameter hpos_t  H_SYNC_END   = vga_timing_pkg::H_SYNC_END,
  parameter vline_t V_TOTAL      = vga_timing_pkg::V_TOTAL,
  parameter vline_t V_VISIBLE    = vga_timing_pkg::V_VISIBLE,
  parameter vline_t V_SYNC_START = vga_timing_pkg::V_SYNC_START,
  parameter vline_t V_SYNC_END   = vga_timing_pkg::V_SYNC_END,
  parameter logic   SYNC_POL     = vga_timing_pkg::SYNC_POL
) (
  input  logic           Clk,
  input  logic           Reset_n,
  vga_sync_gen_if.slave  bus
);

  vline_t cnt_vertical;
  vline_t v_next;
  vline_t v_line;
  logic   wrap;

  contadorvertical #(
    .V_TOTAL (V_TOTAL)
  ) u_contadorvertical (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .en         (bus.vflag),
    .count      (cnt_vertical),
    .count_next (v_next),
    .wrap       (wrap)
  );

  // The counter register lags the end-of-line pulse by a cycle; use its next value
  // on that cycle so tick 0 of a new line already decodes with the new line number.
  assign v_line = bus.vflag ? v_next : cnt_vertical;

  logic h_active;
  logic v_active;
  logic h_sync_on;
  logic v_sync_on;
  logic active;

  always_comb begin
    h_active  = (bus.cntHorizontal < H_VISIBLE);
    v_active  = (v_line < V_VISIBLE);
    h_sync_on = (bus.cntHorizontal >= H_SYNC_START) && (bus.cntHorizontal <= H_SYNC_END);
    v_sync_on = (v_line >= V_SYNC_START) && (v_line <= V_SYNC_END);
    active    = h_active & v_active;
  end

  // Stage p1: one register between (cntHorizontal, v_line) and every output.
  logic       hsync_p1;
  logic       vsync_p1;
  logic       video_on_p1;
  logic [9:0] pixel_x_p1;
  vline_t     pixel_y_p1;
  logic       frame_start_p1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hsync_p1       <= ~SYNC_POL;
      vsync_p1       <= ~SYNC_POL;
      video_on_p1    <= 1'b0;
      pixel_x_p1     <= '0;
      pixel_y_p1     <= '0;
      frame_start_p1 <= 1'b0;
    end else begin
      hsync_p1       <= h_sync_on ? SYNC_POL : ~SYNC_POL;
      vsync_p1       <= v_sync_on ? SYNC_POL : ~SYNC_POL;
      video_on_p1    <= active;
      pixel_x_p1     <= active ? bus.cntHorizontal[H_W-1:1] : '0;
      pixel_y_p1     <= active ? v_line : '0;
      frame_start_p1 <= wrap;
    end
  end

  assign bus.cntVertical = cnt_vertical;
  assign bus.hsync       = hsync_p1;
  assign bus.vsync       = vsync_p1;
  assign bus.video_on    = video_on_p1;
  assign bus.pixel_x     = pixel_x_p1;
  assign bus.pixel_y     = pixel_y_p1;
  assign bus.frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: reset, line stepping, horizontal/vertical decode,
// frame wrap and back-to-back line pulses against hand-computed expectations.
module tb_vga_sync_gen;

  logic Clk = 1'b0;
  logic Reset_n;

  vga_sync_gen_if bus ();

  vga_sync_gen dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passed = 0;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Pulse reset, then step the line counter to n with back-to-back line pulses.
  task automatic set_line(input int n);
    bus.vflag         = 1'b0;
    bus.cntHorizontal = '0;
    Reset_n = 1'b0;
    #1;
    Reset_n = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.vflag = 1'b1;
      tick();
    end
    bus.vflag = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.cntVertical !== 10'd0) $display("FAIL por_cntVertical got %0d want 0", bus.cntVertical); else passed++;
    checks++; if (bus.hsync !== 1'b1) $display("FAIL por_hsync got %b want 1", bus.hsync); else passed++;
    set_line(200);
    bus.cntHorizontal = 11'd700;
    tick();
    checks++; if (bus.video_on !== 1'b1) $display("FAIL pre_video_on got %b want 1", bus.video_on); else passed++;
    checks++; if (bus.pixel_x !== 10'd350) $display("FAIL pre_pixel_x got %0d want 350", bus.pixel_x); else passed++;
    checks++; if (bus.pixel_y !== 10'd200) $display("FAIL pre_pixel_y got %0d want 200", bus.pixel_y); else passed++;
    checks++; if (bus.cntVertical !== 10'd200) $display("FAIL pre_cntVertical got %0d want 200", bus.cntVertical); else passed++;
    #2;
    Reset_n = 1'b0;
    #1;
    checks++; if (bus.cntVertical !== 10'd0) $display("FAIL rst_cntVertical got %0d want 0", bus.cntVertical); else passed++;
    checks++; if (bus.pixel_x !== 10'd0) $display("FAIL rst_pixel_x got %0d want 0", bus.pixel_x); else passed++;
    checks++; if (bus.pixel_y !== 10'd0) $display("FAIL rst_pixel_y got %0d want 0", bus.pixel_y); else passed++;
    checks++; if (bus.video_on !== 1'b0) $display("FAIL rst_video_on got %b want 0", bus.video_on); else passed++;
    checks++; if (bus.frame_start !== 1'b0) $display("FAIL rst_frame_start got %b want 0", bus.frame_start); else passed++;
    checks++; if (bus.hsync !== 1'b1) $display("FAIL rst_hsync got %b want 1", bus.hsync); else passed++;
    checks++; if (bus.vsync !== 1'b1) $display("FAIL rst_vsync got %b want 1", bus.vsync); else passed++;
    Reset_n = 1'b1;
    tick();
    checks++; if (bus.video_on !== 1'b1) $display("FAIL post_video_on got %b want 1", bus.video_on); else passed++;
    checks++; if (bus.pixel_x !== 10'd350) $display("FAIL post_pixel_x got %0d want 350", bus.pixel_x); else passed++;
    checks++; if (bus.pixel_y !== 10'd0) $display("FAIL post_pixel_y got %0d want 0", bus.pixel_y); else passed++;
    bus.cntHorizontal = 11'd1400;
    tick();
    checks++; if (bus.hsync !== 1'b0) $display("FAIL post_hsync got %b want 0", bus.hsync); else passed++;
  endtask

  task automatic test_line_increment();
    set_line(9);
    bus.cntHorizontal = 11'd0;
    bus.vflag = 1'b1;
    tick();
    bus.vflag = 1'b0;
    checks++; if (bus.cntVertical !== 10'd10) $display("FAIL inc_cntVertical got %0d want 10", bus.cntVertical); else passed++;
    checks++; if (bus.pixel_y !== 10'd10) $display("FAIL inc_pixel_y got %0d want 10", bus.pixel_y); else passed++;
    checks++; if (bus.pixel_x !== 10'd0) $display("FAIL inc_pixel_x got %0d want 0", bus.pixel_x); else passed++;
    checks++; if (bus.video_on !== 1'b1) $display("FAIL inc_video_on got %b want 1", bus.video_on); else passed++;
    tick();
    checks++; if (bus.cntVertical !== 10'd10) $display("FAIL inc_hold got %0d want 10", bus.cntVertical); else passed++;
  endtask

  task automatic test_hdecode();
    logic       exp_von;
    logic       exp_hs;
    logic [9:0] exp_px;
    int         hv;
    set_line(5);
    for (int h = 0; h < 1602; h++) begin
      hv = (h < 1600) ? h : ((h == 1600) ? 1700 : 2047);
      bus.cntHorizontal = hv[10:0];
      tick();
      exp_von = (hv < 1280);
      exp_hs  = !((hv >= 1312) && (hv <= 1503));
      exp_px  = exp_von ? 10'(hv / 2) : 10'd0;
      checks++; if (bus.video_on !== exp_von) $display("FAIL h_video_on h=%0d got %b want %b", hv, bus.video_on, exp_von); else passed++;
      checks++; if (bus.hsync !== exp_hs) $display("FAIL h_hsync h=%0d got %b want %b", hv, bus.hsync, exp_hs); else passed++;
      checks++; if (bus.pixel_x !== exp_px) $display("FAIL h_pixel_x h=%0d got %0d want %0d", hv, bus.pixel_x, exp_px); else passed++;
    end
    bus.cntHorizontal = 11'd1279;
    tick();
    checks++; if (bus.pixel_x !== 10'd639) $display("FAIL h_pixel_x_max got %0d want 639", bus.pixel_x); else passed++;
    checks++; if (bus.cntVertical !== 10'd5) $display("FAIL h_line_kept got %0d want 5", bus.cntVertical); else passed++;
  endtask

  task automatic test_vsync();
    logic exp_vs;
    set_line(488);
    for (int l = 489; l <= 492; l++) begin
      exp_vs = !((l == 490) || (l == 491));
      bus.cntHorizontal = 11'd0;
      bus.vflag = 1'b1;
      tick();
      bus.vflag = 1'b0;
      checks++; if (bus.vsync !== exp_vs) $display("FAIL v_vsync_t0 line=%0d got %b want %b", l, bus.vsync, exp_vs); else passed++;
      checks++; if (bus.video_on !== 1'b0) $display("FAIL v_video_on_t0 line=%0d got %b want 0", l, bus.video_on); else passed++;
      bus.cntHorizontal = 11'd1000;
      tick();
      checks++; if (bus.vsync !== exp_vs) $display("FAIL v_vsync_mid line=%0d got %b want %b", l, bus.vsync, exp_vs); else passed++;
      checks++; if (bus.video_on !== 1'b0) $display("FAIL v_video_on_mid line=%0d got %b want 0", l, bus.video_on); else passed++;
      checks++; if (bus.cntVertical !== 10'(l)) $display("FAIL v_cntVertical got %0d want %0d", bus.cntVertical, l); else passed++;
    end
  endtask

  task automatic test_frame_wrap();
    int fs_cnt;
    set_line(524);
    bus.cntHorizontal = 11'd0;
    bus.vflag = 1'b1;
    tick();
    bus.vflag = 1'b0;
    checks++; if (bus.cntVertical !== 10'd0) $display("FAIL wrap_cntVertical got %0d want 0", bus.cntVertical); else passed++;
    checks++; if (bus.frame_start !== 1'b1) $display("FAIL wrap_frame_start got %b want 1", bus.frame_start); else passed++;
    checks++; if (bus.pixel_y !== 10'd0) $display("FAIL wrap_pixel_y got %0d want 0", bus.pixel_y); else passed++;
    checks++; if (bus.video_on !== 1'b1) $display("FAIL wrap_video_on got %b want 1", bus.video_on); else passed++;
    bus.cntHorizontal = 11'd2;
    tick();
    checks++; if (bus.frame_start !== 1'b0) $display("FAIL wrap_pulse_end got %b want 0", bus.frame_start); else passed++;
    checks++; if (bus.pixel_x !== 10'd1) $display("FAIL wrap_pixel_x got %0d want 1", bus.pixel_x); else passed++;
    // Two frames of compressed two-tick lines from reset.
    set_line(0);
    fs_cnt = 0;
    for (int i = 0; i < 1050; i++) begin
      bus.cntHorizontal = 11'd0;
      bus.vflag = 1'b1;
      tick();
      if (bus.frame_start === 1'b1) fs_cnt++;
      bus.cntHorizontal = 11'd1;
      bus.vflag = 1'b0;
      tick();
      if (bus.frame_start === 1'b1) fs_cnt++;
      if (i == 523) begin
        checks++; if (fs_cnt !== 0) $display("FAIL frames_first got %0d want 0", fs_cnt); else passed++;
      end
      if (i == 524) begin
        checks++; if (fs_cnt !== 1) $display("FAIL frames_one got %0d want 1", fs_cnt); else passed++;
      end
    end
    checks++; if (fs_cnt !== 2) $display("FAIL frames_two got %0d want 2", fs_cnt); else passed++;
    checks++; if (bus.cntVertical !== 10'd0) $display("FAIL frames_end_line got %0d want 0", bus.cntVertical); else passed++;
  endtask

  task automatic test_back_to_back();
    set_line(100);
    bus.cntHorizontal = 11'd0;
    bus.vflag = 1'b1;
    tick();
    checks++; if (bus.pixel_y !== 10'd101) $display("FAIL b2b_first got %0d want 101", bus.pixel_y); else passed++;
    tick();
    tick();
    bus.vflag = 1'b0;
    checks++; if (bus.cntVertical !== 10'd103) $display("FAIL b2b_cntVertical got %0d want 103", bus.cntVertical); else passed++;
    checks++; if (bus.pixel_y !== 10'd103) $display("FAIL b2b_pixel_y got %0d want 103", bus.pixel_y); else passed++;
    tick();
    checks++; if (bus.cntVertical !== 10'd103) $display("FAIL b2b_hold got %0d want 103", bus.cntVertical); else passed++;
  endtask

  initial begin
    Reset_n = 1'b0;
    bus.cntHorizontal = '0;
    bus.vflag = 1'b0;
    #12;
    test_reset();
    test_line_increment();
    test_hdecode();
    test_vsync();
    test_frame_wrap();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
